// File: rtl/split_bits_serializer.sv
// Word-to-bit serializer: loads a WIDTH-bit word on a valid/ready handshake and
// emits it one bit per accepted beat, flagging the final bit with last_o.
module split_bits_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     bit_o,
  output logic                     bit_valid_o,
  input  logic                     bit_ready_i,
  output logic                     last_o,
  output logic [$clog2(WIDTH)-1:0] idx_o
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } stateType;

  stateType         state;
  logic [WIDTH-1:0] shiftReg;
  logic [WIDTH-1:0] shifted;
  logic [IDX_W-1:0] nextIdx;
  logic             loadWord;
  logic             beat;

  function automatic logic firstBit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // ready_o is the only combinational output: a word may load on the same edge
  // that the final bit of the previous word is accepted, giving zero bubbles.
  always_comb begin
    ready_o  = (state == IDLE) || (last_o && bit_ready_i);
    loadWord = valid_i && ready_o;
    beat     = bit_valid_o && bit_ready_i;
    shifted  = MSB_FIRST ? (shiftReg << 1) : (shiftReg >> 1);
    nextIdx  = idx_o + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shiftReg    <= '0;
      bit_o       <= 1'b0;
      bit_valid_o <= 1'b0;
      last_o      <= 1'b0;
      idx_o       <= '0;
    end else if (loadWord) begin
      state       <= SHIFT;
      shiftReg    <= data_i;
      bit_o       <= firstBit(data_i);
      bit_valid_o <= 1'b1;
      last_o      <= 1'b0;
      idx_o       <= '0;
    end else if (beat && last_o) begin
      state       <= IDLE;
      shiftReg    <= '0;
      bit_o       <= 1'b0;
      bit_valid_o <= 1'b0;
      last_o      <= 1'b0;
      idx_o       <= '0;
    end else if (beat) begin
      shiftReg <= shifted;
      bit_o    <= firstBit(shifted);
      last_o   <= (nextIdx == LAST_IDX);
      idx_o    <= nextIdx;
    end
  end

endmodule

// File: tb/tb_split_bits_serializer.sv
// Randomized bench for split_bits_serializer: MSB-first and LSB-first instances share
// stimulus and are compared each cycle against a queue-of-pending-bits reference model.
module tb_split_bits_serializer;

  localparam int WIDTH = 4;
  localparam int IW    = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic             valid_i = 1'b0;
  logic             bit_ready_i = 1'b0;

  logic          readyM, bitM, bitValidM, lastM;
  logic [IW-1:0] idxM;
  logic          readyL, bitL, bitValidL, lastL;
  logic [IW-1:0] idxL;

  int vectors = 0;
  int miscompares = 0;

  // Pending bits of the word in flight, in transmission order.
  bit qM[$];
  bit qL[$];

  always #5 clk = ~clk;

  split_bits_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .ready_o(readyM),
    .bit_o(bitM), .bit_valid_o(bitValidM), .bit_ready_i(bit_ready_i),
    .last_o(lastM), .idx_o(idxM)
  );

  split_bits_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .ready_o(readyL),
    .bit_o(bitL), .bit_valid_o(bitValidL), .bit_ready_i(bit_ready_i),
    .last_o(lastL), .idx_o(idxL)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkOutputs(input string tag);
    int n;
    n = qM.size();
    check({tag, ".m.valid"}, 32'(bitValidM), 32'(n != 0));
    check({tag, ".m.bit"},   32'(bitM),      32'(n != 0 ? qM[0] : 1'b0));
    check({tag, ".m.idx"},   32'(idxM),      32'(n != 0 ? WIDTH - n : 0));
    check({tag, ".m.last"},  32'(lastM),     32'(n == 1));
    check({tag, ".m.ready"}, 32'(readyM),    32'(n == 0 || (n == 1 && bit_ready_i)));
    n = qL.size();
    check({tag, ".l.valid"}, 32'(bitValidL), 32'(n != 0));
    check({tag, ".l.bit"},   32'(bitL),      32'(n != 0 ? qL[0] : 1'b0));
    check({tag, ".l.idx"},   32'(idxL),      32'(n != 0 ? WIDTH - n : 0));
    check({tag, ".l.last"},  32'(lastL),     32'(n == 1));
    check({tag, ".l.ready"}, 32'(readyL),    32'(n == 0 || (n == 1 && bit_ready_i)));
  endtask

  // One cycle: drive at negedge, check just after, then apply the handshake rules at posedge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input string tag);
    bit canLoad;
    valid_i     = v;
    data_i      = d;
    bit_ready_i = r;
    #1 checkOutputs(tag);
    canLoad = (qM.size() == 0) || (qM.size() == 1 && r);
    @(posedge clk);
    if (qM.size() != 0 && r) begin
      qM.delete(0);
      qL.delete(0);
    end
    if (v && canLoad) begin
      for (int i = 0; i < WIDTH; i++) begin
        qM.push_back(d[WIDTH-1-i]);
        qL.push_back(d[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic midCycleReset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    qM.delete();
    qL.delete();
    check({tag, ".m.valid"}, 32'(bitValidM), 32'd0);
    check({tag, ".m.bit"},   32'(bitM),      32'd0);
    check({tag, ".m.idx"},   32'(idxM),      32'd0);
    check({tag, ".m.last"},  32'(lastM),     32'd0);
    check({tag, ".l.valid"}, 32'(bitValidL), 32'd0);
    check({tag, ".l.bit"},   32'(bitL),      32'd0);
    check({tag, ".l.idx"},   32'(idxL),      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, "idle");

    // Single word, full-rate consumer; both bit orders observed together.
    step(1'b1, 4'b1011, 1'b1, "t2.load");
    repeat (5) step(1'b0, '0, 1'b1, "t2.bits");

    // Stall at idx 1 with spurious valid pulses, then resume.
    step(1'b1, 4'b0110, 1'b1, "t4.load");
    step(1'b0, '0, 1'b1, "t4.b0");
    repeat (3) step(1'b1, 4'b1111, 1'b0, "t4.stall");
    repeat (4) step(1'b0, '0, 1'b1, "t4.resume");

    // Back-to-back words with valid_i held: no bubble between them.
    step(1'b1, 4'b1011, 1'b1, "t5.load");
    repeat (4) step(1'b1, 4'b0110, 1'b1, "t5.hold");
    repeat (5) step(1'b0, '0, 1'b1, "t5.drain");

    // Reset mid-word after two bits, then a fresh word with no residue.
    step(1'b1, 4'b1100, 1'b1, "t6.load");
    repeat (2) step(1'b0, '0, 1'b1, "t6.bits");
    midCycleReset("t6.rst");
    step(1'b0, '0, 1'b1, "t6.postrst");
    step(1'b1, 4'b0011, 1'b1, "t6.reload");
    repeat (5) step(1'b0, '0, 1'b1, "t6.fresh");

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 9) < 7), "rand");
    end

    // Random mid-word resets.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, WIDTH'($urandom), 1'b1, "rrst.load");
      repeat ($urandom_range(0, 2)) step(1'b0, '0, 1'($urandom_range(0, 1)), "rrst.bits");
      midCycleReset("rrst.rst");
      step(1'b0, '0, 1'b1, "rrst.post");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
